gyro_spi_responder: RTL and testbench
=====================================

# gyro_spi_responder

SPI slave that emulates the gyro PMOD at the far end of the gyro SPI link. It decodes command bytes, keeps a small register map, and serves angular-rate and temperature samples over MISO. It is used in simulation as the bus model for the gyro FSM, and on-board as a loopback target when no physical PMOD is present.

## Interface
- WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F
- CTRL1_RST, 8'h07, reset value of CTRL_REG1 (0x20)
- clk  in  1  system clock, at least 8× SCLK frequency
- rst  in  1  reset, synchronous, active-high
- sclk  in  1  SPI clock, asynchronous, SPI mode 3 (idle high)
- ss_n  in  1  slave select, asynchronous, active-low
- mosi  in  1  master-out data, asynchronous
- miso  out  1  slave-out data, registered
- miso_oe  out  1  MISO drive enable; 1 while synchronized ss_n is low
- x_in, y_in, z_in  in  16 each  new axis samples
- temp_in  in  8  new temperature sample
- sample_valid  in  1  one-cycle strobe qualifying x_in/y_in/z_in/temp_in
- ctrl_reg1  out  8  current CTRL_REG1 contents
- cfg_wr  out  1  one-cycle pulse when a byte is committed to CTRL_REG1

## Operation
- Synchronization: sclk, ss_n and mosi each pass through a 2-FF synchronizer. Edges are detected against a one-cycle-delayed copy.
- Register map:
  - 0x0F WHO_AM_I, read-only.
  - 0x20 CTRL_REG1, read/write.
  - 0x26 OUT_TEMP.
  - 0x28–0x2D: OUT_X_L, OUT_X_H, OUT_Y_L, OUT_Y_H, OUT_Z_L, OUT_Z_H.
  - All other addresses read 0x00; writes to them are ignored.
- Command byte, MSB first: bit7 RW (1 = read), bit6 MS (1 = auto-increment), bits5:0 address.
- FSM states:
  - IDLE → CMD on the ss_n falling edge; the bit counter clears.
  - CMD: shift mosi in on each SCLK rising edge. On the 8th bit, latch RW, MS and addr, then go to DATA.
  - DATA, read: on every byte boundary (the CMD 8th bit, and each DATA 8th bit), load tx_shift with reg[addr]. If MS=1, addr increments.
  - DATA, write: on each DATA 8th rising edge, commit the received byte to reg[addr]. If MS=1, addr increments.
  - Any state → IDLE on the ss_n rising edge.
- MISO: on each SCLK falling edge while in DATA-read, miso <= tx_shift[7] and tx_shift shifts left. During CMD and DATA-write, miso is 0.
- Address arithmetic: 6-bit, wraps 0x3F → 0x00. With MS=0 the address is held.
- Sample coherence:
  - sample_valid with ss_n high writes the OUT_* registers directly.
  - sample_valid with ss_n low stores the sample in a pending buffer; the latest one wins.
  - The pending buffer is applied on the cycle after the ss_n rising edge is detected.
- Boundary conditions:
  - ss_n rises mid-byte: the partial byte is discarded, nothing is committed, cfg_wr stays 0, and the bit counter resets.
  - ss_n low with SCLK idle: no state change.
  - SCLK edges while ss_n is high: ignored.
  - rst mid-transaction: immediate return to IDLE, all registers go to reset values, and the pending buffer clears.

## Timing
- Reset values:
  - miso 0, miso_oe 0, ctrl_reg1 CTRL1_RST, cfg_wr 0.
  - OUT_* 0x00, pending flag 0, state IDLE.
- Latency from raw pin edge to action is 2 sync cycles plus 1 detect cycle. miso changes exactly 3 clk cycles after the raw SCLK falling edge.
- miso_oe follows raw ss_n with 2 clk cycles of latency.
- cfg_wr asserts 3 clk cycles after the raw 8th SCLK rising edge of a write byte to 0x20. ctrl_reg1 updates in that same cycle.
- The first data bit of a read is valid on MISO before the master's first data-byte rising edge, provided half an SCLK period is at least 4 clk cycles.

## Structure
- gyro_pkg (shared with the gyro FSM) holds:
  - address constants: ADDR_WHO_AM_I, ADDR_CTRL1, ADDR_TEMP, ADDR_OUT_X_L;
  - command bit positions RW_BIT and MS_BIT;
  - the responder state enum.
- Sub-module spi_sync_edge: a 2-FF synchronizer plus rise/fall pulse outputs, instantiated for sclk and ss_n. mosi uses its synchronizer only.

## Test plan
- Reset, then read 0x8F → MISO returns 0xD3; ctrl_reg1 = 0x07.
- Write burst 0x20, 0x0F → ctrl_reg1 = 0x0F, and one cfg_wr pulse. Read 0xA0 → returns 0x0F.
- Load x=0x1234, y=0xABCD, z=0x8001 with ss_n high, then burst read 0xE8 + 6 dummy bytes → returns 34 12 CD AB 01 80.
- sample_valid (x=0x5555) during the burst above → the burst still returns the old bytes. A following read 0xE8 returns 55 55 for X.
- Write 0x20 with ss_n raised after 5 data bits → ctrl_reg1 is unchanged and cfg_wr never pulses. A subsequent clean read returns the prior value.
- Burst read 0xFF (MS, addr 0x3F) for 2 bytes → returns 0x00 then 0x00 (addr wraps to 0x00). Read 0x8F after this still returns 0xD3.

Source files
------------

// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro SPI link: register addresses, command
// byte layout and the responder state encoding.
package gyro_pkg;

    localparam logic [7:0] WHO_AM_I_VAL = 8'hD3;
    localparam logic [7:0] CTRL1_RST    = 8'h07;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_TEMP     = 6'h26;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;

    // Command byte: bit7 = read, bit6 = auto-increment, bits5:0 = address
    localparam int unsigned RW_BIT = 7;
    localparam int unsigned MS_BIT = 6;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData
    } resp_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle rise and
// fall pulses derived against a one-cycle-delayed copy of the synced level.
module spi_sync_edge #(
    parameter logic RstVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, prev_q;

    // Synchronizer chain plus delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= RstVal;
            s2_q   <= RstVal;
            prev_q <= RstVal;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign dout = s2_q;
    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/gyro_spi_responder.sv
// SPI mode-3 slave emulating the gyro PMOD: decodes command bytes, holds
// CTRL_REG1 and the sample registers, and serves reads over MISO.
module gyro_spi_responder
    import gyro_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    input  logic [7:0]  temp_in,
    input  logic        sample_valid,
    output logic [7:0]  ctrl_reg1,
    output logic        cfg_wr
);

    logic unused_sclk_lvl;
    logic sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_s1_q, mosi_s2_q;

    spi_sync_edge #(.RstVal(1'b1)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .dout (unused_sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RstVal(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss_n),
        .dout (ss_lvl),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    // mosi only needs a level; matching latency with sclk keeps sampling aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    resp_state_e state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_q;
    logic [7:0]  tx_q;
    logic [5:0]  addr_q;
    logic        rw_q, ms_q;
    logic        miso_q, cfg_wr_q;
    logic [7:0]  ctrl_q;

    logic [15:0] x_q, y_q, z_q;
    logic [7:0]  temp_q;
    logic [15:0] pend_x_q, pend_y_q, pend_z_q;
    logic [7:0]  pend_temp_q;
    logic        pend_valid_q;
    logic        ss_rise_q;

    logic [7:0] rx_next;
    logic [5:0] cmd_addr;
    logic [5:0] addr_next;

    assign rx_next   = {rx_q, mosi_s2_q};
    assign cmd_addr  = rx_next[5:0];
    assign addr_next = ms_q ? addr_q + 6'd1 : addr_q;

    function automatic logic [7:0] reg_read(input logic [5:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            ADDR_WHO_AM_I:        v = WHO_AM_I_VAL;
            ADDR_CTRL1:           v = ctrl_q;
            ADDR_TEMP:            v = temp_q;
            ADDR_OUT_X_L:         v = x_q[7:0];
            ADDR_OUT_X_L + 6'd1:  v = x_q[15:8];
            ADDR_OUT_X_L + 6'd2:  v = y_q[7:0];
            ADDR_OUT_X_L + 6'd3:  v = y_q[15:8];
            ADDR_OUT_X_L + 6'd4:  v = z_q[7:0];
            ADDR_OUT_X_L + 6'd5:  v = z_q[15:8];
            default:              v = 8'h00;
        endcase
        return v;
    endfunction

    // Transaction FSM: command decode, read shifting and CTRL_REG1 commits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            addr_q    <= 6'd0;
            rw_q      <= 1'b0;
            ms_q      <= 1'b0;
            miso_q    <= 1'b0;
            cfg_wr_q  <= 1'b0;
            ctrl_q    <= CTRL1_RST;
        end else begin
            cfg_wr_q <= 1'b0;
            if (ss_rise) begin
                // Any partial byte is dropped here
                state_q   <= StIdle;
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
            end else if (ss_fall) begin
                state_q   <= StCmd;
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StCmd: begin
                        if (sclk_rise) begin
                            rx_q      <= rx_next[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rw_q    <= rx_next[RW_BIT];
                                ms_q    <= rx_next[MS_BIT];
                                state_q <= StData;
                                if (rx_next[RW_BIT]) begin
                                    tx_q   <= reg_read(cmd_addr);
                                    addr_q <= rx_next[MS_BIT] ? cmd_addr + 6'd1 : cmd_addr;
                                end else begin
                                    addr_q <= cmd_addr;
                                end
                            end
                        end
                    end
                    StData: begin
                        if (rw_q) begin
                            if (sclk_fall) begin
                                miso_q <= tx_q[7];
                                tx_q   <= {tx_q[6:0], 1'b0};
                            end else if (sclk_rise) begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    tx_q   <= reg_read(addr_q);
                                    addr_q <= addr_next;
                                end
                            end
                        end else if (sclk_rise) begin
                            rx_q      <= rx_next[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                // Only CTRL_REG1 is writable
                                if (addr_q == ADDR_CTRL1) begin
                                    ctrl_q   <= rx_next;
                                    cfg_wr_q <= 1'b1;
                                end
                                addr_q <= addr_next;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Sample registers; samples arriving mid-transaction wait until ss_n rises
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            z_q          <= 16'd0;
            temp_q       <= 8'd0;
            pend_x_q     <= 16'd0;
            pend_y_q     <= 16'd0;
            pend_z_q     <= 16'd0;
            pend_temp_q  <= 8'd0;
            pend_valid_q <= 1'b0;
            ss_rise_q    <= 1'b0;
        end else begin
            ss_rise_q <= ss_rise;
            if (sample_valid && ss_lvl) begin
                // A fresh direct sample supersedes anything pending
                x_q          <= x_in;
                y_q          <= y_in;
                z_q          <= z_in;
                temp_q       <= temp_in;
                pend_valid_q <= 1'b0;
            end else if (sample_valid) begin
                pend_x_q     <= x_in;
                pend_y_q     <= y_in;
                pend_z_q     <= z_in;
                pend_temp_q  <= temp_in;
                pend_valid_q <= 1'b1;
            end else if (ss_rise_q && pend_valid_q) begin
                x_q          <= pend_x_q;
                y_q          <= pend_y_q;
                z_q          <= pend_z_q;
                temp_q       <= pend_temp_q;
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = ~ss_lvl;
    assign ctrl_reg1 = ctrl_q;
    assign cfg_wr    = cfg_wr_q;

endmodule

// File: tb/tb_gyro_spi_responder.sv
// Directed bench for gyro_spi_responder: acts as a mode-3 SPI master and
// checks register reads/writes, sample coherence and abort/reset behaviour.
module tb_gyro_spi_responder;

    localparam int HALF = 80;  // half SCLK period in ns (8 clk cycles)

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, ss_n, mosi;
    logic        miso, miso_oe;
    logic [15:0] x_in, y_in, z_in;
    logic [7:0]  temp_in;
    logic        sample_valid;
    logic [7:0]  ctrl_reg1;
    logic        cfg_wr;

    int n_checks = 0;
    int n_errors = 0;
    int cfg_cnt  = 0;

    logic [7:0] rx_buf [8];
    logic [7:0] r;

    gyro_spi_responder dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .ss_n         (ss_n),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .temp_in      (temp_in),
        .sample_valid (sample_valid),
        .ctrl_reg1    (ctrl_reg1),
        .cfg_wr       (cfg_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cfg_wr === 1'b1) cfg_cnt <= cfg_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_begin();
        ss_n = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        ss_n = 1'b0;
        ss_n = 1'b1;
        #(HALF * 2);
    endtask

    // Mode 3: drive mosi on the falling edge, sample miso at the rising edge
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, input int nbits);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            mosi = tx[i];
            #HALF;
            sclk = 1'b1;
            rx[i] = miso;
            #HALF;
        end
    endtask

    task automatic read_bytes(input logic [7:0] cmd, input int n);
        logic [7:0] t;
        spi_begin();
        spi_byte(cmd, t, 8);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, t, 8);
            rx_buf[i] = t;
        end
        spi_end();
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z, input logic [7:0] t);
        x_in = x;
        y_in = y;
        z_in = z;
        temp_in = t;
        sample_valid = 1'b1;
        #10;
        sample_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sclk = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        x_in = '0;
        y_in = '0;
        z_in = '0;
        temp_in = '0;
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #20;

        check_eq("rst_miso", {31'd0, miso}, 32'd0);
        check_eq("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check_eq("rst_ctrl", {24'd0, ctrl_reg1}, 32'h07);
        check_eq("rst_cfg_wr", {31'd0, cfg_wr}, 32'd0);

        // WHO_AM_I
        read_bytes(8'h8F, 1);
        check_eq("whoami", {24'd0, rx_buf[0]}, 32'hD3);
        check_eq("ctrl_init", {24'd0, ctrl_reg1}, 32'h07);

        // Write CTRL_REG1 then read it back
        spi_begin();
        check_eq("oe_active", {31'd0, miso_oe}, 32'd1);
        spi_byte(8'h20, r, 8);
        spi_byte(8'h0F, r, 8);
        spi_end();
        check_eq("oe_idle", {31'd0, miso_oe}, 32'd0);
        check_eq("ctrl_wr", {24'd0, ctrl_reg1}, 32'h0F);
        check_eq("cfg_wr_cnt", cfg_cnt, 32'd1);
        read_bytes(8'hA0, 1);
        check_eq("ctrl_rd", {24'd0, rx_buf[0]}, 32'h0F);

        // Samples loaded while idle, then burst read of OUT_X_L..OUT_Z_H
        pulse_sample(16'h1234, 16'hABCD, 16'h8001, 8'h5A);
        #20;
        read_bytes(8'hE8, 6);
        check_eq("burst0", {24'd0, rx_buf[0]}, 32'h34);
        check_eq("burst1", {24'd0, rx_buf[1]}, 32'h12);
        check_eq("burst2", {24'd0, rx_buf[2]}, 32'hCD);
        check_eq("burst3", {24'd0, rx_buf[3]}, 32'hAB);
        check_eq("burst4", {24'd0, rx_buf[4]}, 32'h01);
        check_eq("burst5", {24'd0, rx_buf[5]}, 32'h80);
        read_bytes(8'hA6, 1);
        check_eq("temp", {24'd0, rx_buf[0]}, 32'h5A);

        // New sample mid-burst must not disturb the transfer
        spi_begin();
        spi_byte(8'hE8, r, 8);
        spi_byte(8'h00, r, 8);
        check_eq("coh_b0", {24'd0, r}, 32'h34);
        pulse_sample(16'h5555, 16'hABCD, 16'h8001, 8'h5A);
        spi_byte(8'h00, r, 8);
        check_eq("coh_b1", {24'd0, r}, 32'h12);
        spi_byte(8'h00, r, 8);
        check_eq("coh_b2", {24'd0, r}, 32'hCD);
        spi_end();
        read_bytes(8'hE8, 2);
        check_eq("pend_x_l", {24'd0, rx_buf[0]}, 32'h55);
        check_eq("pend_x_h", {24'd0, rx_buf[1]}, 32'h55);

        // Write aborted after 5 data bits
        spi_begin();
        spi_byte(8'h20, r, 8);
        spi_byte(8'hA5, r, 5);
        spi_end();
        check_eq("abort_ctrl", {24'd0, ctrl_reg1}, 32'h0F);
        check_eq("abort_cfg_cnt", cfg_cnt, 32'd1);
        read_bytes(8'hA0, 1);
        check_eq("abort_rd", {24'd0, rx_buf[0]}, 32'h0F);

        // Auto-increment wraps 0x3F -> 0x00
        read_bytes(8'hFF, 2);
        check_eq("wrap0", {24'd0, rx_buf[0]}, 32'h00);
        check_eq("wrap1", {24'd0, rx_buf[1]}, 32'h00);
        read_bytes(8'h8F, 1);
        check_eq("whoami_again", {24'd0, rx_buf[0]}, 32'hD3);

        // Reset mid-transaction with a pending sample
        spi_begin();
        spi_byte(8'h20, r, 8);
        pulse_sample(16'h7777, 16'h7777, 16'h7777, 8'h77);
        rst = 1'b1;
        #20;
        rst = 1'b0;
        #10;
        check_eq("midrst_ctrl", {24'd0, ctrl_reg1}, 32'h07);
        check_eq("midrst_miso", {31'd0, miso}, 32'd0);
        #HALF;
        spi_end();
        read_bytes(8'hE8, 2);
        check_eq("midrst_x_l", {24'd0, rx_buf[0]}, 32'h00);
        check_eq("midrst_x_h", {24'd0, rx_buf[1]}, 32'h00);
        check_eq("midrst_cfg_cnt", cfg_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
